// File: rtl/wishbone_2mst_arbiter.sv
// wishbone_2mst_arbiter: round-robin two-master Wishbone arbiter with cycle-locked ownership.
// Define WB_ARB_TIMEOUT_EN to add a stalled-strobe timeout ack returning TIMEOUT_DATA.
module wishbone_2mst_arbiter #(
    parameter int                   TIMEOUT_W      = 8,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 8'd255,
    parameter logic [31:0]          TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_m0_cyc_i,
    input  logic        wbs_m0_stb_i,
    input  logic        wbs_m0_we_i,
    input  logic [31:0] wbs_m0_adr_i,
    input  logic [31:0] wbs_m0_dat_i,
    input  logic [3:0]  wbs_m0_sel_i,
    output logic [31:0] wbs_m0_dat_o,
    output logic        wbs_m0_ack_o,
    input  logic        wbs_m1_cyc_i,
    input  logic        wbs_m1_stb_i,
    input  logic        wbs_m1_we_i,
    input  logic [31:0] wbs_m1_adr_i,
    input  logic [31:0] wbs_m1_dat_i,
    input  logic [3:0]  wbs_m1_sel_i,
    output logic [31:0] wbs_m1_dat_o,
    output logic        wbs_m1_ack_o,
    output logic        wbs_s_cyc_o,
    output logic        wbs_s_stb_o,
    output logic        wbs_s_we_o,
    output logic [31:0] wbs_s_adr_o,
    output logic [31:0] wbs_s_dat_o,
    output logic [3:0]  wbs_s_sel_o,
    input  logic [31:0] wbs_s_dat_i,
    input  logic        wbs_s_ack_i,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t state, state_nxt;
    logic prio, own0, own1, cyc, stb, ack, to;
    logic [31:0] rdat;
    assign own0 = state == OWN0;
    assign own1 = state == OWN1;
    assign cyc  = own0 ? wbs_m0_cyc_i : own1 ? wbs_m1_cyc_i : 1'b0;
    assign stb  = own0 ? wbs_m0_stb_i : own1 ? wbs_m1_stb_i : 1'b0;
    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = (wbs_m0_cyc_i && (!wbs_m1_cyc_i || !prio)) ? OWN0 : wbs_m1_cyc_i ? OWN1 : IDLE;
        else if (!cyc)
            state_nxt = IDLE;
    end
    // On release the pointer moves to the master that did not just own the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != IDLE && !cyc)
                prio <= own0;
        end
    end
`ifdef WB_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt;
    assign to = stb && !wbs_s_ack_i && cnt == TIMEOUT_CYCLES - 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (stb && !wbs_s_ack_i && !to && state_nxt != IDLE) ? cnt + 1'b1 : '0;
    end
`else
    assign to = 1'b0;
`endif
    assign timeout_o    = to;
    assign ack          = stb && (wbs_s_ack_i || to);
    assign rdat         = to ? TIMEOUT_DATA : wbs_s_dat_i;
    assign wbs_m0_ack_o = own0 && ack;
    assign wbs_m1_ack_o = own1 && ack;
    assign wbs_m0_dat_o = own0 ? rdat : 32'd0;
    assign wbs_m1_dat_o = own1 ? rdat : 32'd0;
    assign wbs_s_cyc_o  = cyc;
    assign wbs_s_stb_o  = stb && !to;
    assign wbs_s_we_o   = own0 ? wbs_m0_we_i  : own1 ? wbs_m1_we_i  : 1'b0;
    assign wbs_s_adr_o  = own0 ? wbs_m0_adr_i : own1 ? wbs_m1_adr_i : 32'd0;
    assign wbs_s_dat_o  = own0 ? wbs_m0_dat_i : own1 ? wbs_m1_dat_i : 32'd0;
    assign wbs_s_sel_o  = own0 ? wbs_m0_sel_i : own1 ? wbs_m1_sel_i : 4'd0;
endmodule
